// File: rtl/latency_dp_ram_v2.sv
// Single-clock true dual-port RAM with per-port write-commit and read latency,
// read-valid strobes, selectable read-during-write and write-write arbitration.
module latency_dp_ram_v2 #(
  parameter int DATA_WIDTH    = 8,
  parameter int MEM_DEPTH     = 16,
  parameter int ADDR_WIDTH    = $clog2(MEM_DEPTH),
  parameter int WR_LATENCYA   = 1,
  parameter int WR_LATENCYB   = 1,
  parameter int RD_LATENCYA   = 1,
  parameter int RD_LATENCYB   = 1,
  parameter int RDW_MODE      = 0,
  parameter int COLL_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_ena,
  input  logic                  i_wea,
  input  logic [ADDR_WIDTH-1:0] i_addra,
  input  logic [DATA_WIDTH-1:0] i_dina,
  input  logic                  i_enb,
  input  logic                  i_web,
  input  logic [ADDR_WIDTH-1:0] i_addrb,
  input  logic [DATA_WIDTH-1:0] i_dinb,
  output logic [DATA_WIDTH-1:0] o_douta,
  output logic                  o_valida,
  output logic [DATA_WIDTH-1:0] o_doutb,
  output logic                  o_validb,
  output logic                  o_collision
);

  // Request protocol: no handshake. i_enX=1 on a rising edge accepts one request
  // on port X unconditionally; o_validX qualifies o_doutX for exactly one cycle.
  localparam int PW = ADDR_WIDTH + DATA_WIDTH;
  localparam logic L_PRIO_B  = (COLL_PRIORITY == 1);
  localparam logic L_WFIRST  = (RDW_MODE == 1);
  localparam logic L_POW2    = (MEM_DEPTH == (1 << ADDR_WIDTH));
  localparam logic [ADDR_WIDTH:0] L_DEPTH = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return L_POW2 || ({1'b0, a} < L_DEPTH);
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_wa_v, w_wb_v;
  logic [PW-1:0]         w_wa_pkt, w_wb_pkt;
  logic [ADDR_WIDTH-1:0] w_wa_a, w_wb_a;
  logic [DATA_WIDTH-1:0] w_wa_d, w_wb_d;
  logic                  w_ra_v, w_rb_v;
  logic [DATA_WIDTH-1:0] w_ra_d, w_rb_d;
  logic [DATA_WIDTH-1:0] w_rda, w_rdb;

  // Latency 1 commits on the sampling edge, so only LAT-1 register stages exist.
  if (WR_LATENCYA > 1) begin : g_wpipe_a
    logic          r_v [WR_LATENCYA-1];
    logic [PW-1:0] r_p [WR_LATENCYA-1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < WR_LATENCYA-1; k++) begin
          r_v[k] <= 1'b0;
          r_p[k] <= '0;
        end
      end else begin
        r_v[0] <= i_ena & i_wea;
        r_p[0] <= {i_addra, i_dina};
        for (int k = 1; k < WR_LATENCYA-1; k++) begin
          r_v[k] <= r_v[k-1];
          r_p[k] <= r_p[k-1];
        end
      end
    end
    assign w_wa_v   = r_v[WR_LATENCYA-2];
    assign w_wa_pkt = r_p[WR_LATENCYA-2];
  end else begin : g_wdir_a
    assign w_wa_v   = i_ena & i_wea & rst_n;
    assign w_wa_pkt = {i_addra, i_dina};
  end

  if (WR_LATENCYB > 1) begin : g_wpipe_b
    logic          r_v [WR_LATENCYB-1];
    logic [PW-1:0] r_p [WR_LATENCYB-1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < WR_LATENCYB-1; k++) begin
          r_v[k] <= 1'b0;
          r_p[k] <= '0;
        end
      end else begin
        r_v[0] <= i_enb & i_web;
        r_p[0] <= {i_addrb, i_dinb};
        for (int k = 1; k < WR_LATENCYB-1; k++) begin
          r_v[k] <= r_v[k-1];
          r_p[k] <= r_p[k-1];
        end
      end
    end
    assign w_wb_v   = r_v[WR_LATENCYB-2];
    assign w_wb_pkt = r_p[WR_LATENCYB-2];
  end else begin : g_wdir_b
    assign w_wb_v   = i_enb & i_web & rst_n;
    assign w_wb_pkt = {i_addrb, i_dinb};
  end

  assign {w_wa_a, w_wa_d} = w_wa_pkt;
  assign {w_wb_a, w_wb_d} = w_wb_pkt;

  // Collisions are judged at commit time, so mismatched latencies can still collide.
  logic w_ca, w_cb, w_coll, w_wen_a, w_wen_b;
  assign w_ca    = w_wa_v & in_range(w_wa_a);
  assign w_cb    = w_wb_v & in_range(w_wb_a);
  assign w_coll  = w_ca & w_cb & (w_wa_a == w_wb_a);
  assign w_wen_a = w_ca & ~(w_coll & L_PRIO_B);
  assign w_wen_b = w_cb & ~(w_coll & ~L_PRIO_B);

  always_ff @(posedge clk) begin
    if (w_wen_a) r_mem[w_wa_a] <= w_wa_d;
    if (w_wen_b) r_mem[w_wb_a] <= w_wb_d;
  end

  always_comb begin
    w_rda = '0;
    if (in_range(i_addra)) w_rda = r_mem[i_addra];
    if (L_WFIRST && w_wen_a && (w_wa_a == i_addra)) w_rda = w_wa_d;
    if (L_WFIRST && w_wen_b && (w_wb_a == i_addra)) w_rda = w_wb_d;
  end

  always_comb begin
    w_rdb = '0;
    if (in_range(i_addrb)) w_rdb = r_mem[i_addrb];
    if (L_WFIRST && w_wen_a && (w_wa_a == i_addrb)) w_rdb = w_wa_d;
    if (L_WFIRST && w_wen_b && (w_wb_a == i_addrb)) w_rdb = w_wb_d;
  end

  if (RD_LATENCYA > 1) begin : g_rpipe_a
    logic                  r_v [RD_LATENCYA-1];
    logic [DATA_WIDTH-1:0] r_d [RD_LATENCYA-1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < RD_LATENCYA-1; k++) begin
          r_v[k] <= 1'b0;
          r_d[k] <= '0;
        end
      end else begin
        r_v[0] <= i_ena & ~i_wea;
        r_d[0] <= w_rda;
        for (int k = 1; k < RD_LATENCYA-1; k++) begin
          r_v[k] <= r_v[k-1];
          r_d[k] <= r_d[k-1];
        end
      end
    end
    assign w_ra_v = r_v[RD_LATENCYA-2];
    assign w_ra_d = r_d[RD_LATENCYA-2];
  end else begin : g_rdir_a
    assign w_ra_v = i_ena & ~i_wea;
    assign w_ra_d = w_rda;
  end

  if (RD_LATENCYB > 1) begin : g_rpipe_b
    logic                  r_v [RD_LATENCYB-1];
    logic [DATA_WIDTH-1:0] r_d [RD_LATENCYB-1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < RD_LATENCYB-1; k++) begin
          r_v[k] <= 1'b0;
          r_d[k] <= '0;
        end
      end else begin
        r_v[0] <= i_enb & ~i_web;
        r_d[0] <= w_rdb;
        for (int k = 1; k < RD_LATENCYB-1; k++) begin
          r_v[k] <= r_v[k-1];
          r_d[k] <= r_d[k-1];
        end
      end
    end
    assign w_rb_v = r_v[RD_LATENCYB-2];
    assign w_rb_d = r_d[RD_LATENCYB-2];
  end else begin : g_rdir_b
    assign w_rb_v = i_enb & ~i_web;
    assign w_rb_d = w_rdb;
  end

  // Output data registers only load on a valid read, so they hold between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_douta     <= '0;
      o_valida    <= 1'b0;
      o_doutb     <= '0;
      o_validb    <= 1'b0;
      o_collision <= 1'b0;
    end else begin
      o_valida    <= w_ra_v;
      o_validb    <= w_rb_v;
      o_collision <= w_coll;
      if (w_ra_v) o_douta <= w_ra_d;
      if (w_rb_v) o_doutb <= w_rb_d;
    end
  end

endmodule

// File: tb/tb_latency_dp_ram_v2.sv
// Directed bench for latency_dp_ram_v2: two instances with different latency,
// read-during-write and collision settings, each fed by its own stimulus.
module tb_latency_dp_ram_v2;

  logic       clk = 1'b0;
  logic       rst_n [2];
  logic       ena [2], wea [2], enb [2], web [2];
  logic [3:0] addra [2], addrb [2];
  logic [7:0] dina [2], dinb [2];
  logic [7:0] douta [2], doutb [2];
  logic       valida [2], validb [2], coll [2];

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q_a0 [$];
  logic [7:0] exp_q_b0 [$];
  logic [7:0] exp_q_a1 [$];
  logic [7:0] exp_q_b1 [$];
  logic [7:0] exp_mem [16];

  // u0: write-first off, port A wins; u1: write-first on, port B wins.
  latency_dp_ram_v2 #(
    .DATA_WIDTH(8), .MEM_DEPTH(16), .WR_LATENCYA(3), .WR_LATENCYB(4),
    .RD_LATENCYA(2), .RD_LATENCYB(1), .RDW_MODE(0), .COLL_PRIORITY(0)
  ) u0 (
    .clk(clk), .rst_n(rst_n[0]),
    .i_ena(ena[0]), .i_wea(wea[0]), .i_addra(addra[0]), .i_dina(dina[0]),
    .i_enb(enb[0]), .i_web(web[0]), .i_addrb(addrb[0]), .i_dinb(dinb[0]),
    .o_douta(douta[0]), .o_valida(valida[0]),
    .o_doutb(doutb[0]), .o_validb(validb[0]), .o_collision(coll[0])
  );

  latency_dp_ram_v2 #(
    .DATA_WIDTH(8), .MEM_DEPTH(16), .WR_LATENCYA(1), .WR_LATENCYB(2),
    .RD_LATENCYA(4), .RD_LATENCYB(1), .RDW_MODE(1), .COLL_PRIORITY(1)
  ) u1 (
    .clk(clk), .rst_n(rst_n[1]),
    .i_ena(ena[1]), .i_wea(wea[1]), .i_addra(addra[1]), .i_dina(dina[1]),
    .i_enb(enb[1]), .i_web(web[1]), .i_addrb(addrb[1]), .i_dinb(dinb[1]),
    .o_douta(douta[1]), .o_valida(valida[1]),
    .o_doutb(doutb[1]), .o_validb(validb[1]), .o_collision(coll[1])
  );

  // clock / reset
  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle_all();
    for (int u = 0; u < 2; u++) begin
      ena[u] = 1'b0; wea[u] = 1'b0; enb[u] = 1'b0; web[u] = 1'b0;
    end
  endtask

  task automatic drv(input int u, input bit pb, input bit we, input int addr, input int din);
    if (!pb) begin
      ena[u] = 1'b1; wea[u] = we; addra[u] = addr[3:0]; dina[u] = din[7:0];
    end else begin
      enb[u] = 1'b1; web[u] = we; addrb[u] = addr[3:0]; dinb[u] = din[7:0];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle_all();
  endtask

  // scoreboard: every valid output pops one expected read
  always @(negedge clk) begin
    if (valida[0]) begin
      chk("u0_a_read_pending", exp_q_a0.size() != 0, 1);
      if (exp_q_a0.size() != 0) chk("u0_a_data", douta[0], exp_q_a0.pop_front());
    end
    if (validb[0]) begin
      chk("u0_b_read_pending", exp_q_b0.size() != 0, 1);
      if (exp_q_b0.size() != 0) chk("u0_b_data", doutb[0], exp_q_b0.pop_front());
    end
    if (valida[1]) begin
      chk("u1_a_read_pending", exp_q_a1.size() != 0, 1);
      if (exp_q_a1.size() != 0) chk("u1_a_data", douta[1], exp_q_a1.pop_front());
    end
    if (validb[1]) begin
      chk("u1_b_read_pending", exp_q_b1.size() != 0, 1);
      if (exp_q_b1.size() != 0) chk("u1_b_data", doutb[1], exp_q_b1.pop_front());
    end
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst_n[u] = 1'b0;
      addra[u] = '0; addrb[u] = '0; dina[u] = '0; dinb[u] = '0;
    end
    idle_all();
    repeat (3) step();
    for (int u = 0; u < 2; u++) begin
      chk("rst_douta", douta[u], 0);
      chk("rst_valida", valida[u], 0);
      chk("rst_doutb", doutb[u], 0);
      chk("rst_validb", validb[u], 0);
      chk("rst_collision", coll[u], 0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    step();

    // u0 write latency 3 / read latency 2
    drv(0, 0, 1, 4, 'h5A); step();
    repeat (3) step();
    drv(0, 0, 1, 4, 'hA5); step();                              // edge 1
    drv(0, 0, 0, 4, 0); exp_q_a0.push_back(8'h5A); step();      // edge 2
    step();                                                     // edge 3 commit
    drv(0, 0, 0, 4, 0); exp_q_a0.push_back(8'hA5); step();      // edge 4
    step();                                                     // edge 5
    chk("u0_lat_valid_e5", valida[0], 1);
    chk("u0_lat_data_e5", douta[0], 'hA5);
    step();
    chk("u0_lat_valid_drop", valida[0], 0);
    chk("u0_lat_hold", douta[0], 'hA5);

    // u0 read-first: B reads addr 7 on A's commit edge
    drv(0, 0, 1, 7, 'h11); step();
    repeat (3) step();
    drv(0, 0, 1, 7, 'h3C); step();
    step();
    drv(0, 1, 0, 7, 0); exp_q_b0.push_back(8'h11); step();
    chk("u0_rdw_old", doutb[0], 'h11);
    drv(0, 1, 0, 7, 0); exp_q_b0.push_back(8'h3C); step();
    chk("u0_rdw_after", doutb[0], 'h3C);
    repeat (2) step();

    // u0 reset with a write and a read in flight
    drv(0, 1, 1, 2, 'h66); step();
    repeat (4) step();
    drv(0, 1, 1, 2, 'hFF); step();
    drv(0, 0, 0, 4, 0); step();
    #2 rst_n[0] = 1'b0;
    #1;
    chk("u0_rstmid_douta", douta[0], 0);
    chk("u0_rstmid_doutb", doutb[0], 0);
    chk("u0_rstmid_valida", valida[0], 0);
    chk("u0_rstmid_validb", validb[0], 0);
    chk("u0_rstmid_coll", coll[0], 0);
    repeat (2) step();
    rst_n[0] = 1'b1;
    repeat (4) step();
    drv(0, 1, 0, 2, 0); exp_q_b0.push_back(8'h66);
    drv(0, 0, 0, 4, 0); exp_q_a0.push_back(8'hA5);
    step();
    repeat (3) step();

    // u0 idle: valids low, data held
    for (int i = 0; i < 10; i++) begin
      step();
      chk("u0_idle_valida", valida[0], 0);
      chk("u0_idle_validb", validb[0], 0);
      chk("u0_idle_douta", douta[0], 'hA5);
      chk("u0_idle_doutb", doutb[0], 'h66);
    end

    // u1 write-first: B reads addr 7 on A's commit edge
    drv(1, 0, 1, 7, 'h11); step();
    step();
    drv(1, 0, 1, 7, 'h3C); drv(1, 1, 0, 7, 0); exp_q_b1.push_back(8'h3C); step();
    chk("u1_rdw_new", doutb[1], 'h3C);
    step();

    // u1 collision from mismatched latencies, B has priority
    drv(1, 1, 1, 9, 'h22); step();
    chk("u1_coll_before", coll[1], 0);
    drv(1, 0, 1, 9, 'h11); drv(1, 1, 0, 9, 0); exp_q_b1.push_back(8'h22); step();
    chk("u1_coll_pulse", coll[1], 1);
    step();
    chk("u1_coll_clear", coll[1], 0);
    drv(1, 0, 0, 9, 0); exp_q_a1.push_back(8'h22); step();
    repeat (5) step();

    // u1 same commit edge, different addresses
    drv(1, 1, 1, 10, 'h0A); step();
    drv(1, 0, 1, 11, 'h0B); step();
    chk("u1_nocoll", coll[1], 0);
    drv(1, 1, 0, 10, 0); exp_q_b1.push_back(8'h0A); step();
    drv(1, 1, 0, 11, 0); exp_q_b1.push_back(8'h0B); step();
    step();

    // u1 streaming reads with read latency 4
    for (int i = 0; i < 16; i++) begin
      exp_mem[i] = 8'($urandom_range(0, 255));
      drv(1, 0, 1, i, exp_mem[i]); step();
    end
    step();
    for (int n = 1; n <= 22; n++) begin
      if (n <= 16) begin
        drv(1, 0, 0, n - 1, 0);
        exp_q_a1.push_back(exp_mem[n-1]);
      end
      step();
      chk("u1_stream_valid", valida[1], (n >= 4 && n <= 19));
    end

    repeat (4) step();
    chk("u0_a_queue_empty", exp_q_a0.size(), 0);
    chk("u0_b_queue_empty", exp_q_b0.size(), 0);
    chk("u1_a_queue_empty", exp_q_a1.size(), 0);
    chk("u1_b_queue_empty", exp_q_b1.size(), 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/latency_dp_ram_v2.md
Name: latency_dp_ram_v2

Overview:
- Single-clock, true dual-port RAM with independently parametrised write and read latency per port.
- Write requests (address, data, enable) travel a per-port delay pipeline before committing to the array.
- Read data travels a per-port output pipeline and is qualified by a valid strobe.
- Successor of the two-clock latency RAM top. Adds:
  - asynchronous reset of all pipeline state
  - read-valid outputs
  - selectable read-during-write mode
  - defined write-write collision arbitration with a collision flag

Parameters:
- DATA_WIDTH, 8, data word width in bits.
- MEM_DEPTH, 16, number of words.
- ADDR_WIDTH, $clog2(MEM_DEPTH), address width.
- WR_LATENCYA, 1, port-A write commit latency in clock edges; legal range 1..8.
- WR_LATENCYB, 1, port-B write commit latency; legal range 1..8.
- RD_LATENCYA, 1, port-A read latency; legal range 1..8.
- RD_LATENCYB, 1, port-B read latency; legal range 1..8.
- RDW_MODE, 0, read-during-write behaviour: 0 = READ_FIRST (old data), 1 = WRITE_FIRST (new data).
- COLL_PRIORITY, 0, winning port on a same-address simultaneous commit: 0 = port A, 1 = port B.

Ports:
- clk  input  1  single clock for both ports; all logic on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- i_ena  input  1  port-A request enable.
- i_wea  input  1  port-A write select (1 = write, 0 = read), qualified by i_ena.
- i_addra  input  ADDR_WIDTH  port-A address.
- i_dina  input  DATA_WIDTH  port-A write data.
- i_enb  input  1  port-B request enable.
- i_web  input  1  port-B write select.
- i_addrb  input  ADDR_WIDTH  port-B address.
- i_dinb  input  DATA_WIDTH  port-B write data.
- o_douta  output  DATA_WIDTH  port-A read data.
- o_valida  output  1  port-A read data valid.
- o_doutb  output  DATA_WIDTH  port-B read data.
- o_validb  output  1  port-B read data valid.
- o_collision  output  1  one-cycle pulse indicating a same-address write-write commit.

Behaviour:
- Request sampling: on each edge, i_enX=1 samples a request on port X. i_enX=0 is a no-op. No backpressure; one request per port per cycle.
- Write pipeline:
  - A write (i_enX=1, i_weX=1) sampled at edge E1 commits to the array at edge E_WR_LATENCYX, where the sampling edge is E1.
  - WR_LATENCY=1 commits at the sampling edge.
  - Pipeline stages carry valid, address and data. Back-to-back writes every cycle are supported.
- Read pipeline:
  - A read (i_enX=1, i_weX=0) samples the array at edge E1.
  - Data and o_validX=1 are registered out at edge E_RD_LATENCYX and stay valid for exactly one cycle per read.
  - Back-to-back reads yield consecutive valid cycles.
  - When o_validX=0, o_doutX holds its last value.
- Read-during-write: a read samples address N on the same edge that a delayed write commits to N from either port.
  - RDW_MODE=0: the read returns the pre-commit contents.
  - RDW_MODE=1: the read returns the committing data. If both ports commit to N, it returns the winning port's data.
- Write-write collision: both ports commit to the same address on the same edge.
  - The COLL_PRIORITY port's data is stored; the other write is discarded.
  - o_collision=1 for exactly the following cycle.
  - Different addresses commit independently with no flag.
- Latency mismatch: collision is evaluated at commit time, not issue time. Writes issued on different cycles that reach commit together do collide.
- Address range: addresses are ADDR_WIDTH bits. If MEM_DEPTH is not a power of two, out-of-range writes are dropped and out-of-range reads return 0 with valid asserted.
- Reset (rst_n=0, asynchronous):
  - All pipeline valid bits clear.
  - o_douta, o_doutb = 0; o_valida, o_validb, o_collision = 0.
  - Array contents are not reset.
  - Writes still in a pipeline when reset asserts are dropped and never commit.
  - Reads in flight produce no valid.
  - After rst_n rises, the first edge samples requests normally.

Test Plan:
- WR_LATENCYA=3, RD_LATENCYA=2: write 0xA5 to addr 4 at edge 1; read addr 4 at edges 2 and 4 -> the edge-2 read returns the old value; the edge-4 read returns 0xA5, with o_valida high after edge 5.
- RDW_MODE=0 vs RDW_MODE=1: port B reads addr 7 on port A's commit edge of 0x3C over 0x11 -> o_doutb = 0x11 (mode 0) / 0x3C (mode 1).
- WR_LATENCYA=1, WR_LATENCYB=2, COLL_PRIORITY=1: B writes 0x22 to addr 9 at edge 1; A writes 0x11 to addr 9 at edge 2 -> both commit at edge 2; addr 9 = 0x22; o_collision pulses for one cycle after edge 2.
- Streaming: port A reads addrs 0..15 on 16 consecutive cycles with RD_LATENCYA=4 -> o_valida high for 16 consecutive cycles starting after edge 4, data in address order.
- Reset mid-flight: WR_LATENCYB=4; write 0xFF to addr 2; assert rst_n low 2 cycles later -> all outputs immediately 0; a later read of addr 2 returns the pre-write value.
- Idle: i_ena=i_enb=0 for 10 cycles after reads -> o_valida and o_validb stay 0; o_douta and o_doutb hold their last values.
